hand_display_ctrl: RTL and testbench

//  Stores the cards of one blackjack hand and drives the 7-seg digits for it.

---
 rtl/hand_display_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hand_display_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hand_display_ctrl.sv
// rtl/hand_display_ctrl.sv - one blackjack hand: card storage, best total, 7-seg card cycling and bust blink
module hand_display_ctrl #(
  parameter int MAX_CARDS   = 8,
  parameter int DWELL_TICKS = 50_000_000,
  parameter int BLINK_TICKS = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       card_valid,
  input  logic [5:0] card_code,
  input  logic       clear_hand,
  output logic       card_accept,
  output logic [3:0] hand_count,
  output logic [6:0] hand_total,
  output logic       bust,
  output logic       full,
  output logic [6:0] seg_card,
  output logic [6:0] seg_card_t,
  output logic [6:0] seg_card_o,
  output logic [6:0] seg_idx,
  output logic [6:0] seg_tot1,
  output logic [6:0] seg_tot0
);

  localparam int IW = (MAX_CARDS > 1) ? $clog2(MAX_CARDS) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [3:0]    CAP        = 4'(MAX_CARDS);
  localparam logic [6:0]    BLANK      = 7'b1111111;

  typedef enum logic [1:0] {EMPTY, SHOW, BUST} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_codes [MAX_CARDS];
  logic [3:0]    r_count;
  logic [6:0]    r_hard;
  logic          r_has_ace;
  logic          r_accept;
  logic [IW-1:0] r_disp_idx;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;
  logic [6:0]    r_seg_card, r_seg_card_t, r_seg_card_o, r_seg_idx, r_seg_tot1, r_seg_tot0;

  logic       w_full;
  logic       w_accept;
  logic [6:0] w_card_val;
  logic [6:0] w_new_hard;
  logic       w_new_ace;
  logic [6:0] w_total;
  logic [6:0] w_new_total;
  logic [3:0] w_code;
  logic [6:0] w_tens, w_ones;
  logic [6:0] w_card, w_card_t, w_card_o, w_idx, w_tot1, w_tot0;

  function automatic logic [6:0] f_digit(input logic [6:0] d);
    case (d)
      7'd0:    f_digit = 7'b1000000;
      7'd1:    f_digit = 7'b1111001;
      7'd2:    f_digit = 7'b0100100;
      7'd3:    f_digit = 7'b0110000;
      7'd4:    f_digit = 7'b0011001;
      7'd5:    f_digit = 7'b0010010;
      7'd6:    f_digit = 7'b0000010;
      7'd7:    f_digit = 7'b1111000;
      7'd8:    f_digit = 7'b0000000;
      7'd9:    f_digit = 7'b0010000;
      default: f_digit = BLANK;
    endcase
  endfunction

  function automatic logic [6:0] f_card_glyph(input logic [3:0] c);
    if (c == 4'd0)       f_card_glyph = 7'b0001000;
    else if (c <= 4'd8)  f_card_glyph = f_digit(7'(c) + 7'd1);
    else if (c == 4'd10) f_card_glyph = 7'b1110001;
    else if (c == 4'd11) f_card_glyph = 7'b0011000;
    else if (c == 4'd12) f_card_glyph = 7'b0001011;
    else                 f_card_glyph = BLANK;
  endfunction

  assign w_full   = (r_count == CAP);
  assign w_accept = card_valid && (card_code <= 6'd12) && !w_full && !clear_hand;

  always_comb begin
    w_card_val = 7'd10;
    if (card_code == 6'd0)      w_card_val = 7'd1;
    else if (card_code <= 6'd8) w_card_val = {1'b0, card_code} + 7'd1;
  end

  assign w_new_hard  = r_hard + w_card_val;
  assign w_new_ace   = r_has_ace || (card_code == 6'd0);
  assign w_total     = (r_has_ace && r_hard <= 7'd11) ? r_hard + 7'd10 : r_hard;
  assign w_new_total = (w_new_ace && w_new_hard <= 7'd11) ? w_new_hard + 7'd10 : w_new_hard;

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  // A hard total above 21 can never come back down, so BUST only leaves on clear.
  always_comb begin
    w_next = r_state;
    if (clear_hand)    w_next = EMPTY;
    else if (w_accept) w_next = (w_new_total > 7'd21) ? BUST : SHOW;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_codes[r_count[IW-1:0]] <= card_code[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset || clear_hand) begin
      r_count     <= 4'd0;
      r_hard      <= 7'd0;
      r_has_ace   <= 1'b0;
      r_accept    <= 1'b0;
      r_disp_idx  <= '0;
      r_dwell     <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else begin
      r_accept <= w_accept;
      if (w_accept) begin
        r_count    <= r_count + 4'd1;
        r_hard     <= w_new_hard;
        r_has_ace  <= w_new_ace;
        r_disp_idx <= r_count[IW-1:0];
        r_dwell    <= '0;
      end else if (r_state != EMPTY) begin
        if (r_dwell == DWELL_LAST) begin
          r_dwell    <= '0;
          r_disp_idx <= (4'(r_disp_idx) + 4'd1 == r_count) ? '0 : r_disp_idx + IW'(1);
        end else begin
          r_dwell <= r_dwell + DW'(1);
        end
      end

      if (w_next == BUST && r_state != BUST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_state == BUST) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end else begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_code   = r_codes[r_disp_idx];
    w_tens   = w_total / 7'd10;
    w_ones   = w_total % 7'd10;
    w_card   = BLANK;
    w_card_t = BLANK;
    w_card_o = BLANK;
    w_idx    = BLANK;
    w_tot1   = BLANK;
    w_tot0   = BLANK;
    if (r_state != EMPTY) begin
      w_idx  = f_digit(7'(r_disp_idx) + 7'd1);
      w_tot1 = (w_total < 7'd10) ? BLANK : f_digit(w_tens);
      w_tot0 = f_digit(w_ones);
      if (r_state != BUST || r_blink_on) begin
        if (w_code == 4'd9) begin
          w_card_t = f_digit(7'd1);
          w_card_o = f_digit(7'd0);
        end else begin
          w_card = f_card_glyph(w_code);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_card   <= BLANK;
      r_seg_card_t <= BLANK;
      r_seg_card_o <= BLANK;
      r_seg_idx    <= BLANK;
      r_seg_tot1   <= BLANK;
      r_seg_tot0   <= BLANK;
    end else begin
      r_seg_card   <= w_card;
      r_seg_card_t <= w_card_t;
      r_seg_card_o <= w_card_o;
      r_seg_idx    <= w_idx;
      r_seg_tot1   <= w_tot1;
      r_seg_tot0   <= w_tot0;
    end
  end

  assign card_accept = r_accept;
  assign hand_count  = r_count;
  assign hand_total  = w_total;
  assign bust        = (w_total > 7'd21);
  assign full        = w_full;
  assign seg_card    = r_seg_card;
  assign seg_card_t  = r_seg_card_t;
  assign seg_card_o  = r_seg_card_o;
  assign seg_idx     = r_seg_idx;
  assign seg_tot1    = r_seg_tot1;
  assign seg_tot0    = r_seg_tot0;

endmodule

// File: tb/tb_hand_display_ctrl.sv
// tb/tb_hand_display_ctrl.sv - vector table with seg scoreboard plus dwell, blink and reset sequences
module tb_hand_display_ctrl;
  localparam int MAXC = 8;
  localparam int DWT  = 4;
  localparam int BLT  = 6;
  localparam logic [6:0] B = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, card_valid, clear_hand, card_accept, bust, full;
  logic [5:0] card_code;
  logic [3:0] hand_count;
  logic [6:0] hand_total, seg_card, seg_card_t, seg_card_o, seg_idx, seg_tot1, seg_tot0;

  hand_display_ctrl #(.MAX_CARDS(MAXC), .DWELL_TICKS(DWT), .BLINK_TICKS(BLT)) dut (
    .clk(clk), .reset(reset), .card_valid(card_valid), .card_code(card_code),
    .clear_hand(clear_hand), .card_accept(card_accept), .hand_count(hand_count),
    .hand_total(hand_total), .bust(bust), .full(full), .seg_card(seg_card),
    .seg_card_t(seg_card_t), .seg_card_o(seg_card_o), .seg_idx(seg_idx),
    .seg_tot1(seg_tot1), .seg_tot0(seg_tot0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [5:0] code; logic clr;
    logic acc; int cnt; int tot;
    logic [6:0] card, ct, co, idx, t1, t0;
  } vec_t;

  typedef struct { logic [6:0] card, ct, co, idx, t1, t0; } seg_exp_t;

  vec_t     tbl[$];
  seg_exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: dig = 7'b1000000; 1: dig = 7'b1111001; 2: dig = 7'b0100100; 3: dig = 7'b0110000;
      4: dig = 7'b0011001; 5: dig = 7'b0010010; 6: dig = 7'b0000010; 7: dig = 7'b1111000;
      8: dig = 7'b0000000; 9: dig = 7'b0010000;
      default: dig = B;
    endcase
  endfunction

  function automatic logic [6:0] card_seg(input int c);
    case (c)
      0: card_seg = 7'b0001000;
      10: card_seg = 7'b1110001;
      11: card_seg = 7'b0011000;
      12: card_seg = 7'b0001011;
      default: card_seg = (c >= 1 && c <= 8) ? dig(c + 1) : B;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic v, input int code, input logic clr, input logic acc,
                         input int cnt, input int tot, input int shown);
    vec_t e;
    e.v = v; e.code = 6'(code); e.clr = clr; e.acc = acc; e.cnt = cnt; e.tot = tot;
    e.card = B; e.ct = B; e.co = B; e.idx = B; e.t1 = B; e.t0 = B;
    if (cnt != 0) begin
      e.idx = dig(cnt);
      e.t1  = (tot < 10) ? B : dig(tot / 10);
      e.t0  = dig(tot % 10);
      if (shown == 9) begin
        e.ct = dig(1);
        e.co = dig(0);
      end else begin
        e.card = card_seg(shown);
      end
    end
    tbl.push_back(e);
  endtask

  task automatic apply(input vec_t t, input int id);
    seg_exp_t s;
    seg_exp_t g;
    @(negedge clk);
    card_valid = t.v; card_code = t.code; clear_hand = t.clr;
    @(posedge clk); #1;
    card_valid = 1'b0; clear_hand = 1'b0; card_code = 6'd0;
    chk($sformatf("v%0d_accept", id), int'(card_accept), int'(t.acc));
    chk($sformatf("v%0d_count", id), int'(hand_count), t.cnt);
    chk($sformatf("v%0d_total", id), int'(hand_total), t.tot);
    chk($sformatf("v%0d_bust", id), int'(bust), int'(t.tot > 21));
    chk($sformatf("v%0d_full", id), int'(full), int'(t.cnt == MAXC));
    s.card = t.card; s.ct = t.ct; s.co = t.co; s.idx = t.idx; s.t1 = t.t1; s.t0 = t.t0;
    sb.push_back(s);
    @(posedge clk); #1;
    g = sb.pop_front();
    chk($sformatf("v%0d_seg_card", id), int'(seg_card), int'(g.card));
    chk($sformatf("v%0d_seg_card_t", id), int'(seg_card_t), int'(g.ct));
    chk($sformatf("v%0d_seg_card_o", id), int'(seg_card_o), int'(g.co));
    chk($sformatf("v%0d_seg_idx", id), int'(seg_idx), int'(g.idx));
    chk($sformatf("v%0d_seg_tot1", id), int'(seg_tot1), int'(g.t1));
    chk($sformatf("v%0d_seg_tot0", id), int'(seg_tot0), int'(g.t0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(hand_count), 0);
    chk({tag, "_total"}, int'(hand_total), 0);
    chk({tag, "_bust"}, int'(bust), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_accept"}, int'(card_accept), 0);
    chk({tag, "_segs"}, int'({seg_card, seg_card_t, seg_card_o, seg_idx, seg_tot1, seg_tot0}),
        int'({B, B, B, B, B, B}));
  endtask

  initial begin
    int dw_codes[3];
    int ph;
    vec_t d;
    dw_codes[0] = 0; dw_codes[1] = 12; dw_codes[2] = 4;
    reset = 1'b1; card_valid = 1'b0; clear_hand = 1'b0; card_code = 6'd0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); reset = 1'b0;

    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 11, 0);
    add_vec(1, 12, 0, 1, 2, 21, 12);
    add_vec(1, 13, 0, 0, 2, 21, 12);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 9, 0, 1, 1, 10, 9);
    add_vec(1, 9, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 1, 11, 0);
    add_vec(1, 0, 0, 1, 2, 12, 0);
    add_vec(1, 8, 0, 1, 3, 21, 8);
    add_vec(1, 4, 0, 1, 4, 16, 4);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    for (int n = 1; n <= MAXC; n++) add_vec(1, 0, 0, 1, n, n + 10, 0);
    add_vec(1, 0, 0, 0, MAXC, MAXC + 10, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(1, 12, 0, 1, 1, 10, 12);
    add_vec(1, 11, 0, 1, 2, 20, 11);
    add_vec(1, 1, 0, 1, 3, 22, 1);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Bust blink: phase after edge e is on while ((e - entry) / BLT) is even; segs lag one edge.
    for (int k = 2; k <= 14; k++) begin
      @(posedge clk); #1;
      ph = ((k - 1) / BLT) % 2;
      chk($sformatf("blink_k%0d_card_blank", k), int'(seg_card == B), ph);
      chk($sformatf("blink_k%0d_card_t", k), int'(seg_card_t), int'(B));
      chk($sformatf("blink_k%0d_tot", k), int'({seg_tot1, seg_tot0}), int'({dig(2), dig(2)}));
      chk($sformatf("blink_k%0d_bust", k), int'(bust), 1);
    end

    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("midblink_reset");
    @(negedge clk); reset = 1'b0;

    tbl.delete();
    add_vec(1, 0, 0, 1, 1, 11, 0);
    add_vec(1, 12, 0, 1, 2, 21, 12);
    add_vec(1, 4, 0, 1, 3, 16, 4);
    for (int i = 0; i < tbl.size(); i++) begin
      d = tbl[i];
      apply(d, 100 + i);
    end

    // Dwell: newest card (index 2) shown first, then advances every DWT edges with wrap.
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      ph = (2 + (k - 1) / DWT) % 3;
      chk($sformatf("dwell_k%0d_idx", k), int'(seg_idx), int'(dig(ph + 1)));
      chk($sformatf("dwell_k%0d_card", k), int'(seg_card), int'(card_seg(dw_codes[ph])));
    end

    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("middwell_reset");
    @(negedge clk); reset = 1'b0;
    tbl.delete();
    add_vec(1, 10, 0, 1, 1, 10, 10);
    apply(tbl[0], 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
